// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates MEM-stage and queued mul/div results onto the register file write port
module writeback_unit #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic        mem_mem_to_reg,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_load_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_dest,
    input  logic [31:0] md_data,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        reg_we,
    output logic        stall_req
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [4:0]    dest_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [CW-1:0] cnt, cnt_nx;
    logic          empty, full, pipe_wr, push, pop, blocked;
    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign md_ready = !rst && !full;
    assign pipe_wr  = mem_valid && mem_reg_write && (mem_dest != 5'd0);
    // $0 results complete the handshake but never occupy an entry
    assign push     = md_valid && md_ready && (md_dest != 5'd0);
    assign pop      = !pipe_wr && !empty;
    assign blocked  = pipe_wr && !empty;
    // starvation count saturates so a persistent pipeline keeps the request raised
    always_comb cnt_nx = !blocked ? '0 : (cnt == CW'(STARVE_MAX)) ? cnt : cnt + 1'b1;
    // FIFO storage needs no reset; pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr[AW-1:0]] <= md_dest;
            data_q[wr_ptr[AW-1:0]] <= md_data;
        end
    end
    // pointers, starvation tracking and the registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            stall_req  <= 1'b0;
            write_reg  <= 5'd0;
            write_data <= 32'd0;
            reg_we     <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + (AW+1)'(push);
            rd_ptr     <= rd_ptr + (AW+1)'(pop);
            cnt        <= cnt_nx;
            stall_req  <= cnt_nx == CW'(STARVE_MAX);
            write_reg  <= pipe_wr ? mem_dest : pop ? dest_q[rd_ptr[AW-1:0]] : 5'd0;
            write_data <= pipe_wr ? (mem_mem_to_reg ? mem_load_data : mem_alu_result) :
                          pop ? data_q[rd_ptr[AW-1:0]] : 32'd0;
            reg_we     <= pipe_wr || pop;
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: table vectors, corner sequences and randomized checks against a queue model
module tb_writeback_unit;
    logic        clk = 1'b0;
    logic        rst, mem_valid, mem_reg_write, mem_mem_to_reg, md_valid, md_ready, reg_we, stall_req;
    logic [4:0]  mem_dest, md_dest, write_reg;
    logic [31:0] mem_alu_result, mem_load_data, md_data, write_data;
    always #5 clk = ~clk;
    writeback_unit #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_dest(mem_dest), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .md_valid(md_valid), .md_ready(md_ready),
        .md_dest(md_dest), .md_data(md_data), .write_reg(write_reg), .write_data(write_data),
        .reg_we(reg_we), .stall_req(stall_req)
    );
    typedef struct packed {logic [4:0] d; logic [31:0] v;} ent_t;
    typedef struct {
        logic mv, m2r, mdv;
        logic [4:0] dest, mdd;
        logic [31:0] alu, ld, mdx;
        logic [4:0] er;
        logic [31:0] ed;
        logic ewe, erdy;
    } vec_t;
    int n_vec = 0, n_miss = 0;
    ent_t q[$];
    int cnt = 0;
    logic [4:0] e_reg;
    logic [31:0] e_data;
    logic e_we, e_stall;
    vec_t tbl[15];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drive(input logic r, input logic mv, input logic m2r, input logic [4:0] d,
                         input logic [31:0] alu, input logic [31:0] ld, input logic mdv,
                         input logic [4:0] mdd, input logic [31:0] mdx);
        rst = r; mem_valid = mv; mem_reg_write = mv; mem_mem_to_reg = m2r; mem_dest = d;
        mem_alu_result = alu; mem_load_data = ld; md_valid = mdv; md_dest = mdd; md_data = mdx;
    endtask
    // advance one clock while the model applies the arbitration rules to the same inputs
    task automatic tick();
        bit pipe, acc;
        ent_t h;
        pipe = mem_valid && mem_reg_write && mem_dest != 0;
        acc = md_valid && !rst && q.size() < 2;
        if (rst) begin
            q.delete(); cnt = 0; e_stall = 0; e_reg = 0; e_data = 0; e_we = 0;
        end else begin
            cnt = (pipe && q.size() > 0) ? (cnt < 4 ? cnt + 1 : 4) : 0;
            e_stall = cnt == 4;
            if (pipe) begin
                e_reg = mem_dest; e_data = mem_mem_to_reg ? mem_load_data : mem_alu_result; e_we = 1;
            end else if (q.size() > 0) begin
                h = q.pop_front(); e_reg = h.d; e_data = h.v; e_we = 1;
            end else begin
                e_reg = 0; e_data = 0; e_we = 0;
            end
            if (acc && md_dest != 0) q.push_back({md_dest, md_data});
        end
        @(posedge clk);
        #1;
    endtask
    task automatic out_chk(input string n, input logic [4:0] r, input logic [31:0] d, input logic we);
        chk({n, "_reg"}, 32'(write_reg), 32'(r));
        chk({n, "_data"}, write_data, d);
        chk({n, "_we"}, 32'(reg_we), 32'(we));
    endtask
    initial begin
        tbl[0]  = '{1,0,0, 5, 0, 32'h1234, 0, 0,           5, 32'h1234, 1, 1};
        tbl[1]  = '{1,1,0, 5, 0, 0, 32'hDEADBEEF, 0,       5, 32'hDEADBEEF, 1, 1};
        tbl[2]  = '{1,0,0, 0, 0, 32'hFFFFFFFF, 0, 0,       0, 0, 0, 1};
        tbl[3]  = '{0,0,1, 0, 0, 0, 0, 32'h55,             0, 0, 0, 1};
        tbl[4]  = '{0,0,0, 0, 0, 0, 0, 0,                  0, 0, 0, 1};
        tbl[5]  = '{1,0,1, 3, 7, 32'h33, 0, 9,             3, 32'h33, 1, 1};
        tbl[6]  = '{0,0,0, 0, 0, 0, 0, 0,                  7, 9, 1, 1};
        tbl[7]  = '{0,0,0, 0, 0, 0, 0, 0,                  0, 0, 0, 1};
        tbl[8]  = '{1,0,1, 1, 8, 32'h11, 0, 32'h80,        1, 32'h11, 1, 1};
        tbl[9]  = '{1,0,1, 2, 9, 32'h22, 0, 32'h90,        2, 32'h22, 1, 1};
        tbl[10] = '{1,0,1, 3, 10, 32'h33, 0, 32'hA0,       3, 32'h33, 1, 0};
        tbl[11] = '{0,0,1, 0, 10, 0, 0, 32'hA0,            8, 32'h80, 1, 0};
        tbl[12] = '{0,0,1, 0, 10, 0, 0, 32'hA0,            9, 32'h90, 1, 1};
        tbl[13] = '{0,0,0, 0, 0, 0, 0, 0,                  10, 32'hA0, 1, 1};
        tbl[14] = '{0,0,0, 0, 0, 0, 0, 0,                  0, 0, 0, 1};
        // reset held two cycles while MEM offers a write
        drive(1, 1, 0, 5, 32'h77, 0, 0, 0, 0);
        tick();
        chk("rst_ready", 32'(md_ready), 0);
        tick();
        out_chk("rst", 0, 0, 0);
        chk("rst_stall", 32'(stall_req), 0);
        rst = 0;
        #1;
        chk("rel_ready", 32'(md_ready), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 15; i++) begin
            drive(0, tbl[i].mv, tbl[i].m2r, tbl[i].dest, tbl[i].alu, tbl[i].ld,
                  tbl[i].mdv, tbl[i].mdd, tbl[i].mdx);
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(md_ready), 32'(tbl[i].erdy));
            tick();
            out_chk($sformatf("tbl%0d", i), tbl[i].er, tbl[i].ed, tbl[i].ewe);
            chk($sformatf("tbl%0d_stall", i), 32'(stall_req), 0);
        end
        // starvation: one queued entry behind a continuous pipeline
        drive(0, 0, 0, 0, 0, 0, 1, 4, 32'h44);
        tick();
        out_chk("stv_push", 0, 0, 0);
        for (int b = 1; b <= 5; b++) begin
            drive(0, 1, 0, 1, 32'(b), 0, 0, 0, 0);
            tick();
            out_chk($sformatf("stv_b%0d", b), 1, 32'(b), 1);
            chk($sformatf("stv_b%0d_stall", b), 32'(stall_req), 32'(b >= 4));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        out_chk("stv_bubble", 4, 32'h44, 1);
        chk("stv_clear", 32'(stall_req), 0);
        // reset while a result is queued drops it
        drive(0, 1, 0, 2, 32'h22, 0, 1, 6, 32'h66);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 6, 32'h66);
        #1;
        chk("mid_rst_ready", 32'(md_ready), 0);
        tick();
        out_chk("mid_rst", 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        out_chk("mid_rst_drop", 0, 0, 0);
        chk("mid_rst_ready2", 32'(md_ready), 1);
        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 4) < 3, 1'($urandom),
                  $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom), $urandom, $urandom,
                  1'($urandom), $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom), $urandom);
            #1;
            chk("rnd_ready", 32'(md_ready), 32'(!rst && q.size() < 2));
            tick();
            out_chk("rnd", e_reg, e_data, e_we);
            chk("rnd_stall", 32'(stall_req), 32'(e_stall));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
